fft_stage_sequencer: RTL and testbench

Frame-level controller for the 32-point radix-2 FFT datapath. Accepts one 32-sample frame through a valid/ready handshake and drives the sample-memory write address. It then sequences the five butterfly stages, including per-stage load strobes, butterfly index, twiddle ROM address and pipeline flush, and finally unloads the result through a second valid/ready handshake. Sits between the sample source and the five-stage butterfly datapath; it is the only source of stage sequencing.

---
 rtl/fft_stage_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_fft_stage_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer
//   Frame-level controller for the 32-point radix-2 FFT datapath. Loads one
//   32-sample frame through a valid/ready handshake, sequences the five
//   butterfly stages (issue enable, stage load strobe, butterfly index,
//   twiddle address, pipeline flush), then unloads the result through a
//   second valid/ready handshake.
//
//   Build option: FFT_BITREV_LOAD_EN
//     defined   - load_addr is the bit-reversed load counter (in-place DIT)
//     undefined - load_addr is the load counter in natural order
//
//   Ports:
//     clk_100       in   system clock, rising edge
//     reset_all     in   synchronous active-high reset
//     in_valid      in   source presents a sample
//     in_ready      out  sequencer accepts a sample (IDLE or LOAD)
//     load_we       out  sample-memory write enable
//     load_addr     out  sample-memory write address
//     bfly_en       out  butterfly issue enable
//     stage_sel     out  current stage 0..4
//     bfly_idx      out  butterfly index within stage 0..15
//     twiddle_addr  out  twiddle ROM address
//     sload         out  one-hot stage load strobe (first butterfly of stage)
//     out_valid     out  result sample available
//     out_ready     in   sink accepts result sample
//     out_addr      out  result-memory read address
//     busy          out  high in every state except IDLE
//     done          out  one-cycle pulse after the last result is accepted
//
//   state  | meaning
//   IDLE   | waiting for the first sample of a frame
//   LOAD   | accepting samples 1..31
//   STAGE  | issuing 16 butterflies of stage stage_sel
//   FLUSH  | waiting BFLY_LAT cycles for the butterfly pipeline to drain
//   UNLOAD | presenting results 0..31 to the sink

module fft_stage_sequencer #(
    parameter int N_POINTS = 32,
    parameter int LOG2N    = 5,
    parameter int BFLY_LAT = 3
) (
    input  logic             clk_100,
    input  logic             reset_all,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             load_we,
    output logic [LOG2N-1:0] load_addr,
    output logic             bfly_en,
    output logic [2:0]       stage_sel,
    output logic [3:0]       bfly_idx,
    output logic [3:0]       twiddle_addr,
    output logic [4:0]       sload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOG2N-1:0] out_addr,
    output logic             busy,
    output logic             done
);

    localparam logic [LOG2N-1:0] LAST_SAMPLE = LOG2N'(N_POINTS - 1);
    localparam logic [3:0]       LAST_BFLY   = 4'(N_POINTS / 2 - 1);
    localparam logic [2:0]       LAST_STAGE  = 3'(LOG2N - 1);
    localparam logic [2:0]       FLUSH_LAST  = 3'(BFLY_LAT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STAGE  = 3'd2,
        FLUSH  = 3'd3,
        UNLOAD = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LOG2N-1:0] load_cnt;
    logic [2:0]       stage_r;
    logic [3:0]       idx_r;
    logic [2:0]       flush_cnt;
    logic [LOG2N-1:0] oaddr_r;
    logic             done_r;

    // state register
    always_ff @(posedge clk_100) begin
        if (reset_all) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (in_valid) state_nxt = LOAD;
            LOAD:   if (in_valid && load_cnt == LAST_SAMPLE) state_nxt = STAGE;
            STAGE:  if (idx_r == LAST_BFLY) state_nxt = FLUSH;
            FLUSH:  if (flush_cnt == 3'd0)
                        state_nxt = (stage_r == LAST_STAGE) ? UNLOAD : STAGE;
            UNLOAD: if (out_ready && oaddr_r == LAST_SAMPLE) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // counters; each one is cleared on the transition that finishes with it
    always_ff @(posedge clk_100) begin
        if (reset_all) begin
            load_cnt  <= '0;
            stage_r   <= '0;
            idx_r     <= '0;
            flush_cnt <= '0;
            oaddr_r   <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= (state == UNLOAD) && out_ready && (oaddr_r == LAST_SAMPLE);
            case (state)
                IDLE: begin
                    if (in_valid) load_cnt <= LOG2N'(1);
                end
                LOAD: begin
                    if (in_valid) begin
                        if (load_cnt == LAST_SAMPLE) begin
                            load_cnt <= '0;
                            stage_r  <= '0;
                            idx_r    <= '0;
                        end else begin
                            load_cnt <= load_cnt + 1'b1;
                        end
                    end
                end
                STAGE: begin
                    if (idx_r == LAST_BFLY) begin
                        idx_r     <= '0;
                        flush_cnt <= FLUSH_LAST;
                    end else begin
                        idx_r <= idx_r + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == 3'd0) begin
                        if (stage_r == LAST_STAGE) begin
                            oaddr_r <= '0;
                        end else begin
                            stage_r <= stage_r + 1'b1;
                        end
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                UNLOAD: begin
                    if (out_ready) begin
                        if (oaddr_r == LAST_SAMPLE) begin
                            oaddr_r <= '0;
                            stage_r <= '0;
                        end else begin
                            oaddr_r <= oaddr_r + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // outputs
    always_comb begin
        in_ready  = (state == IDLE) || (state == LOAD);
        load_we   = in_valid && in_ready;
        bfly_en   = (state == STAGE);
        out_valid = (state == UNLOAD);
        busy      = (state != IDLE);

`ifdef FFT_BITREV_LOAD_EN
        load_addr = '0;
        for (int i = 0; i < LOG2N; i++) begin
            load_addr[i] = load_cnt[LOG2N-1-i];
        end
`else
        load_addr = load_cnt;
`endif

        sload = '0;
        if (state == STAGE && idx_r == 4'd0) begin
            sload = 5'(5'b00001 << stage_r);
        end

        // (idx mod 2^s) << (4 - s): keep the low s bits of idx, left-justified
        case (stage_r)
            3'd1:    twiddle_addr = {idx_r[0],   3'b000};
            3'd2:    twiddle_addr = {idx_r[1:0], 2'b00};
            3'd3:    twiddle_addr = {idx_r[2:0], 1'b0};
            3'd4:    twiddle_addr = idx_r;
            default: twiddle_addr = 4'd0;
        endcase
    end

    assign stage_sel = stage_r;
    assign bfly_idx  = idx_r;
    assign out_addr  = oaddr_r;
    assign done      = done_r;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Testbench for fft_stage_sequencer: randomized and directed stimulus checked
// against a frame-timeline reference model (samples loaded, cycles into the
// processing phase, results unloaded).
module tb_fft_stage_sequencer;

    localparam int LAT    = 3;
    localparam int PERIOD = 16 + LAT;      // cycles per stage incl. flush
    localparam int PROC   = 5 * PERIOD;    // total processing cycles

    logic       clk_100 = 1'b0;
    logic       reset_all;
    logic       in_valid;
    logic       in_ready;
    logic       load_we;
    logic [4:0] load_addr;
    logic       bfly_en;
    logic [2:0] stage_sel;
    logic [3:0] bfly_idx;
    logic [3:0] twiddle_addr;
    logic [4:0] sload;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_addr;
    logic       busy;
    logic       done;

    fft_stage_sequencer #(.N_POINTS(32), .LOG2N(5), .BFLY_LAT(LAT)) dut (
        .clk_100      (clk_100),
        .reset_all    (reset_all),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .load_we      (load_we),
        .load_addr    (load_addr),
        .bfly_en      (bfly_en),
        .stage_sel    (stage_sel),
        .bfly_idx     (bfly_idx),
        .twiddle_addr (twiddle_addr),
        .sload        (sload),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk_100 = ~clk_100;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // reference model: mode 0 = filling, 1 = processing, 2 = draining
    int m_mode;
    int m_loaded;
    int m_t;
    int m_unloaded;
    bit m_done;
    bit m_valid = 1'b0;

    function automatic int exp_laddr(input int n);
        int r;
`ifdef FFT_BITREV_LOAD_EN
        r = 0;
        for (int i = 0; i < 5; i++) r = r * 2 + ((n >> i) & 1);
`else
        r = n;
`endif
        return r;
    endfunction

    task automatic model_step(input bit iv, input bit ordy, input bit rst);
        bit nd;
        nd = 1'b0;
        if (rst) begin
            m_mode = 0; m_loaded = 0; m_t = 0; m_unloaded = 0;
            m_valid = 1'b1;
        end else begin
            case (m_mode)
                0: if (iv) begin
                       m_loaded++;
                       if (m_loaded == 32) begin m_mode = 1; m_t = 0; m_loaded = 0; end
                   end
                1: begin
                       m_t++;
                       if (m_t == PROC) begin m_mode = 2; m_unloaded = 0; end
                   end
                default: if (ordy) begin
                       m_unloaded++;
                       if (m_unloaded == 32) begin m_mode = 0; m_unloaded = 0; nd = 1'b1; end
                   end
            endcase
        end
        m_done = nd;
    endtask

    task automatic compare(input bit iv);
        int s, k;
        s = m_t / PERIOD;
        k = m_t % PERIOD;
        chk("in_ready", in_ready, m_mode == 0);
        chk("load_we", load_we, (m_mode == 0) && iv);
        if (m_mode == 0 && iv) chk("load_addr", load_addr, exp_laddr(m_loaded));
        chk("busy", busy, (m_mode != 0) || (m_loaded != 0));
        chk("done", done, m_done);
        chk("out_valid", out_valid, m_mode == 2);
        chk("bfly_en", bfly_en, (m_mode == 1) && (k < 16));
        chk("sload", sload, (m_mode == 1 && k == 0) ? (1 << s) : 0);
        if (m_mode == 1 && k < 16) begin
            chk("stage_sel", stage_sel, s);
            chk("bfly_idx", bfly_idx, k);
            chk("twiddle_addr", twiddle_addr, ((k % (1 << s)) << (4 - s)) & 15);
        end
        if (m_mode == 0) begin
            chk("idle_stage_sel", stage_sel, 0);
            chk("idle_bfly_idx", bfly_idx, 0);
            chk("idle_out_addr", out_addr, 0);
        end
        if (m_mode == 2) chk("out_addr", out_addr, m_unloaded);
    endtask

    // per-frame observations of DUT events, checked against fixed numbers
    int cyc = 0;
    int last_acc, first_ov, done_cyc, done_cnt, sload_cnt, bfly_cnt;
    int sload_or;

    task automatic clear_meas();
        last_acc = -1; first_ov = -1; done_cyc = -1;
        done_cnt = 0; sload_cnt = 0; bfly_cnt = 0; sload_or = 0;
    endtask

    task automatic step(input bit iv, input bit ordy, input bit rst);
        in_valid  = iv;
        out_ready = ordy;
        reset_all = rst;
        #1;
        if (m_valid) compare(iv);
        if (load_we && load_addr == 5'd31) last_acc = cyc;
        if (out_valid && first_ov < 0) first_ov = cyc;
        if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
        if (sload != 0) begin sload_cnt++; sload_or = sload_or | int'(sload); end
        if (bfly_en) bfly_cnt++;
        @(posedge clk_100);
        model_step(iv, ordy, rst);
        cyc++;
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        in_valid = 0; out_ready = 0; reset_all = 1;
        @(posedge clk_100); #1;
        step(0, 0, 1);
        step(0, 0, 0);

        // full frame, back-to-back input and sink always ready
        clear_meas();
        guard = 0;
        while (done_cyc < 0 && guard < 400) begin step(1, 1, 0); guard++; end
        chk("frame_done_seen", done_cyc >= 0, 1);
        // accept in cycle c; STAGE/FLUSH occupy c+1..c+PROC; out_valid at c+PROC+1
        chk("ov_latency", first_ov - last_acc, PROC + 1);
        chk("done_after_ov", done_cyc - first_ov, 32);
        chk("done_pulses", done_cnt, 1);
        chk("sload_count", sload_cnt, 5);
        chk("sload_onehots", sload_or, 31);
        chk("bfly_en_cycles", bfly_cnt, 80);

        // in_valid held high across done: next frame starts on the done cycle
        for (int i = 0; i < 40; i++) step(1, 1, 0);

        // reset in the middle of stage 3, butterfly 9
        guard = 0;
        while (!(m_mode == 1 && m_t == 3 * PERIOD + 9) && guard < 400) begin
            step(1, 1, 0); guard++;
        end
        chk("reached_stage3_idx9", (m_mode == 1 && m_t == 3 * PERIOD + 9), 1);
        step(1, 1, 1);
        chk("post_reset_busy", busy, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0);

        // alternating in_valid and out_ready
        step(0, 0, 1);
        for (int i = 0; i < 400; i++) step(i[0], i[0], 0);

        // random handshakes
        step(0, 0, 1);
        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
